// File: rtl/score_keeper.sv
// Score keeper for duck-hunt: conditions raw hit/miss strobes, awards streak-weighted
// saturating points, tracks the session high score and produces a BCD copy of the score.
module score_keeper #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MAX_COMBO = 4,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hit,
  input  logic                           miss,
  input  logic                           clear,
  output logic [WIDTH-1:0]               score,
  output logic [WIDTH-1:0]               high_score,
  output logic [$clog2(MAX_COMBO+1)-1:0] combo,
  output logic                           new_record,
  output logic [4*DIGITS-1:0]            score_bcd,
  output logic                           bcd_valid
);

  localparam int unsigned CW = $clog2(MAX_COMBO + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned NW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SCORE_MAX = '1;

  if (MAX_COMBO < 1) begin : g_chk_combo
    $error("score_keeper: MAX_COMBO must be at least 1");
  end
  if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_chk_digits
    $error("score_keeper: DIGITS too small for WIDTH");
  end

  // Two-flop synchronisers followed by rising-edge detectors
  logic hit_s1_q, hit_s2_q, hit_prev_q;
  logic miss_s1_q, miss_s2_q, miss_prev_q;
  logic hit_p, miss_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_s1_q    <= 1'b0;
      hit_s2_q    <= 1'b0;
      hit_prev_q  <= 1'b0;
      miss_s1_q   <= 1'b0;
      miss_s2_q   <= 1'b0;
      miss_prev_q <= 1'b0;
    end else begin
      hit_s1_q    <= hit;
      hit_s2_q    <= hit_s1_q;
      hit_prev_q  <= hit_s2_q;
      miss_s1_q   <= miss;
      miss_s2_q   <= miss_s1_q;
      miss_prev_q <= miss_s2_q;
    end
  end

  assign hit_p  = hit_s2_q & ~hit_prev_q;
  assign miss_p = miss_s2_q & ~miss_prev_q;

  // Scoring: clear beats miss beats hit; award computed one bit wider then saturated
  logic [WIDTH-1:0] score_q, score_d, high_q, high_d;
  logic [CW-1:0]    combo_q, combo_d, combo_hit;
  logic [CW:0]      combo_inc;
  logic [WIDTH:0]   sum;
  logic             new_rec_q, new_rec_d;
  logic             score_chg;

  always_comb begin
    combo_inc = {1'b0, combo_q} + (CW+1)'(1);
    combo_hit = (combo_inc > (CW+1)'(MAX_COMBO)) ? CW'(MAX_COMBO) : combo_inc[CW-1:0];
    sum       = {1'b0, score_q} + (WIDTH+1)'(combo_hit);
    score_d   = score_q;
    combo_d   = combo_q;
    high_d    = high_q;
    new_rec_d = new_rec_q;
    if (clear) begin
      score_d   = '0;
      combo_d   = '0;
      new_rec_d = 1'b0;
    end else if (miss_p) begin
      combo_d = '0;
    end else if (hit_p) begin
      combo_d = combo_hit;
      score_d = sum[WIDTH] ? SCORE_MAX : sum[WIDTH-1:0];
    end
    if (score_d > high_q) begin
      high_d    = score_d;
      new_rec_d = 1'b1;
    end
  end

  assign score_chg = (score_d != score_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q   <= '0;
      high_q    <= '0;
      combo_q   <= '0;
      new_rec_q <= 1'b0;
    end else begin
      score_q   <= score_d;
      high_q    <= high_d;
      combo_q   <= combo_d;
      new_rec_q <= new_rec_d;
    end
  end

  // Double-dabble converter; a score change seen in any busy state restarts from LOAD
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             chg_q;
  logic             load_en, shift_en, write_en;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    acc_q, acc_d, acc_adj;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q;
  logic             bcd_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (chg_q) state_d = S_LOAD;
      S_LOAD:  state_d = chg_q ? S_LOAD : S_SHIFT;
      S_SHIFT: begin
        if (chg_q)                            state_d = S_LOAD;
        else if (cnt_q == NW'(WIDTH - 1))     state_d = S_DONE;
      end
      S_DONE:  state_d = (chg_q || score_chg) ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // DONE withholds its write when the score moved, so a stale value is never shown
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    write_en = 1'b0;
    unique case (state_q)
      S_LOAD:  load_en  = 1'b1;
      S_SHIFT: shift_en = 1'b1;
      S_DONE:  write_en = !(chg_q || score_chg);
      default: ;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    sh_d  = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_en) begin
      sh_d  = score_q;
      acc_d = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      acc_d = {acc_adj[BW-2:0], sh_q[WIDTH-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + NW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg_q       <= 1'b0;
      sh_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b1;
    end else begin
      chg_q       <= score_chg;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      if (write_en) bcd_q <= acc_q;
      bcd_valid_q <= (state_d == S_IDLE);
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign combo      = combo_q;
  assign new_record = new_rec_q;
  assign score_bcd  = bcd_q;
  assign bcd_valid  = bcd_valid_q;

endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed bench for score_keeper against a rule-level reference model.
module tb_score_keeper;

  localparam int unsigned WIDTH     = 7;
  localparam int unsigned MAX_COMBO = 4;
  localparam int unsigned DIGITS    = 3;
  localparam int unsigned CW        = $clog2(MAX_COMBO + 1);
  localparam int          SMAX      = (1 << WIDTH) - 1;

  localparam int EV_HIT    = 0;
  localparam int EV_MISS   = 1;
  localparam int EV_BOTH   = 2;
  localparam int EV_CLEAR  = 3;
  localparam int EV_CLRHIT = 4;

  logic                clk = 1'b0;
  logic                rst, hit, miss, clear;
  logic [WIDTH-1:0]    score, high_score;
  logic [CW-1:0]       combo;
  logic                new_record;
  logic [4*DIGITS-1:0] score_bcd;
  logic                bcd_valid;

  int n_checks = 0;
  int n_errors = 0;
  int m_score  = 0;
  int m_combo  = 0;
  int m_hs     = 0;
  int m_nr     = 0;
  bit bcd_settled = 1'b1;

  score_keeper #(.WIDTH(WIDTH), .MAX_COMBO(MAX_COMBO), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .hit        (hit),
    .miss       (miss),
    .clear      (clear),
    .score      (score),
    .high_score (high_score),
    .combo      (combo),
    .new_record (new_record),
    .score_bcd  (score_bcd),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Game rules applied to one synchronised event
  task automatic model_step(input bit h, input bit m, input bit c);
    int cc;
    if (c) begin
      m_score = 0;
      m_combo = 0;
      m_nr    = 0;
    end else if (m) begin
      m_combo = 0;
    end else if (h) begin
      cc      = (m_combo + 1 > int'(MAX_COMBO)) ? int'(MAX_COMBO) : m_combo + 1;
      m_combo = cc;
      m_score = (m_score + cc > SMAX) ? SMAX : m_score + cc;
    end
    if (m_score > m_hs) begin
      m_hs = m_score;
      m_nr = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_score"}, score, m_score);
    check({tag, "_combo"}, combo, m_combo);
    check({tag, "_high"}, high_score, m_hs);
    check({tag, "_record"}, new_record, m_nr);
  endtask

  task automatic bcd_follow(input bit changed, input bit full);
    int n;
    @(negedge clk);
    if (changed)          check("bcd_busy", bcd_valid, 0);
    else if (bcd_settled) check("bcd_idle", bcd_valid, 1);
    if (full) begin
      n = 0;
      while (bcd_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (changed) check("bcd_latency", n, WIDTH + 2);
      else         check("bcd_wait_bound", 32'(n < 40), 1);
      check("bcd_value", score_bcd, to_bcd(m_score));
      bcd_settled = 1'b1;
    end else if (changed) begin
      bcd_settled = 1'b0;
    end
  endtask

  task automatic do_event(input int kind, input bit full);
    int old;
    bit h, m;
    old = m_score;
    h   = (kind == EV_HIT) || (kind == EV_BOTH) || (kind == EV_CLRHIT);
    m   = (kind == EV_MISS) || (kind == EV_BOTH);
    @(negedge clk);
    if (kind == EV_CLEAR) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_step(1'b0, 1'b0, 1'b1);
    end else begin
      hit  = h;
      miss = m;
      repeat (2) @(negedge clk);
      check("early_score", score, old);
      if (kind == EV_CLRHIT) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      hit   = 1'b0;
      miss  = 1'b0;
      model_step(h, m, kind == EV_CLRHIT);
    end
    check_all("event");
    bcd_follow(m_score != old, full);
    @(negedge clk);
  endtask

  task automatic hold_hit();
    @(negedge clk);
    hit = 1'b1;
    repeat (50) @(negedge clk);
    hit = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    check_all("hold");
    repeat (4) @(negedge clk);
    check_all("hold_after");
    check("hold_bcd", score_bcd, to_bcd(m_score));
    bcd_settled = 1'b1;
  endtask

  task automatic restart_test();
    @(negedge clk);
    hit = 1'b1;
    repeat (3) @(negedge clk);
    hit = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    check("rs_first", score, m_score);
    check("rs_valid_early", bcd_valid, 1);
    repeat (2) @(negedge clk);
    hit = 1'b1;
    repeat (3) @(negedge clk);
    hit = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    check_all("rs_second");
    bcd_follow(1'b1, 1'b1);
    @(negedge clk);
  endtask

  task automatic reset_mid_shift();
    @(negedge clk);
    hit = 1'b1;
    repeat (3) @(negedge clk);
    hit = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    check("ar_score", score, m_score);
    repeat (4) @(negedge clk);
    check("ar_busy", bcd_valid, 0);
    #1 rst = 1'b0;
    #1;
    m_score = 0;
    m_combo = 0;
    m_hs    = 0;
    m_nr    = 0;
    check_all("ar");
    check("ar_bcd", score_bcd, 0);
    check("ar_valid", bcd_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    bcd_settled = 1'b1;
  endtask

  // Whenever the displayed BCD changes it must describe the score currently held
  initial begin : bcd_monitor
    logic [4*DIGITS-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (score_bcd !== prev) begin
        check("bcd_update", score_bcd, to_bcd(int'(score)));
        prev = score_bcd;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int r, kind;
    rst   = 1'b1;
    hit   = 1'b0;
    miss  = 1'b0;
    clear = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_all("reset");
    check("reset_bcd", score_bcd, 0);
    check("reset_valid", bcd_valid, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    repeat (3) do_event(EV_HIT, 1'b1);
    check("streak_score", score, 6);
    check("streak_combo", combo, 3);
    check("streak_bcd", score_bcd, 12'h006);

    repeat (3) do_event(EV_HIT, 1'b1);
    check("cap_score", score, 18);
    check("cap_combo", combo, MAX_COMBO);

    do_event(EV_CLEAR, 1'b1);
    check("clr_score", score, 0);
    check("clr_high", high_score, 18);
    check("clr_record", new_record, 0);
    repeat (6) do_event(EV_HIT, 1'b0);
    check("equal_high_record", new_record, 0);
    do_event(EV_HIT, 1'b1);
    check("beat_high", high_score, 22);
    check("beat_record", new_record, 1);

    do_event(EV_CLEAR, 1'b1);
    do_event(EV_HIT, 1'b1);
    do_event(EV_HIT, 1'b1);
    do_event(EV_MISS, 1'b1);
    check("break_combo", combo, 0);
    do_event(EV_HIT, 1'b1);
    check("break_score", score, 4);
    check("break_combo2", combo, 1);

    hold_hit();
    do_event(EV_BOTH, 1'b1);
    check("both_combo", combo, 0);
    do_event(EV_CLRHIT, 1'b1);
    check("clrhit_score", score, 0);

    restart_test();

    do_event(EV_CLEAR, 1'b1);
    do_event(EV_HIT, 1'b0);
    do_event(EV_HIT, 1'b0);
    do_event(EV_MISS, 1'b0);
    repeat (32) do_event(EV_HIT, 1'b0);
    check("sat_pre_score", score, 125);
    check("sat_pre_combo", combo, 4);
    do_event(EV_HIT, 1'b1);
    check("sat_score", score, 127);
    do_event(EV_HIT, 1'b1);
    check("sat_hold", score, 127);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4 || r == 9) kind = EV_HIT;
      else if (r == 5)      kind = EV_MISS;
      else if (r == 6)      kind = EV_BOTH;
      else if (r == 7)      kind = EV_CLEAR;
      else                  kind = EV_CLRHIT;
      do_event(kind, 1'($urandom_range(0, 1)));
    end

    do_event(EV_CLEAR, 1'b1);
    do_event(EV_HIT, 1'b1);
    reset_mid_shift();
    do_event(EV_HIT, 1'b1);
    check("post_reset_score", score, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
